// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// Consumers import fetch_pkg::* for state encodings and reset vectors.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_CANCEL = 3'd4
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;
    localparam logic [31:0] EXC_PC_DEF   = 32'hbfc00380;
    localparam logic [31:0] NOP          = 32'h00000000;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_npc_sel.sv
// Next-PC select: exception > eret > branch > sequential.
// redir flags any non-sequential target.
module fetch_npc_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] EXC_PC = EXC_PC_DEF
) (
    input  logic        exception,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic [31:0] seq,
    output logic        redir,
    output logic [31:0] npc
);

    assign redir = exception | eret | br_valid;

    always_comb begin
        npc = seq;
        if (exception) begin
            npc = EXC_PC;
        end else if (eret) begin
            npc = epc;
        end else if (br_valid) begin
            npc = br_target;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: single-outstanding instruction port plus 1-entry buffer.
// Optional FETCH_ADEL_CHECK_EN turns misaligned fetches into fs_adel entries.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_PC   = EXC_PC_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exception,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
`ifdef FETCH_ADEL_CHECK_EN
    ,
    output logic        fs_adel
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  pend_q, pend_d;
    logic         fs_valid_q, fs_valid_d;
    logic [31:0]  fs_pc_q, fs_pc_d;
    logic [31:0]  fs_inst_q, fs_inst_d;
    logic         redir;
    logic [31:0]  npc;
    logic         addr_bad;
`ifdef FETCH_ADEL_CHECK_EN
    logic         adel_q, adel_d;
`endif

    fetch_npc_sel #(.EXC_PC(EXC_PC)) u_npc_sel (
        .exception (exception),
        .eret      (eret),
        .epc       (epc),
        .br_valid  (br_valid),
        .br_target (br_target),
        .seq       (seq_pc(fs_pc_q)),
        .redir     (redir),
        .npc       (npc)
    );

`ifdef FETCH_ADEL_CHECK_EN
    assign addr_bad = |addr_q[1:0];
`else
    assign addr_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pend_d     = pend_q;
        fs_valid_d = fs_valid_q;
        fs_pc_d    = fs_pc_q;
        fs_inst_d  = fs_inst_q;
`ifdef FETCH_ADEL_CHECK_EN
        adel_d     = adel_q;
`endif
        // A redirect always invalidates the buffer, stall or not.
        if (redir) begin
            fs_valid_d = 1'b0;
`ifdef FETCH_ADEL_CHECK_EN
            adel_d     = 1'b0;
`endif
        end
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redir) addr_d = npc;
            end
            S_REQ: begin
                if (addr_bad) begin
                    if (redir) begin
                        addr_d = npc;
                    end else begin
                        state_d    = S_HOLD;
                        fs_valid_d = 1'b1;
                        fs_pc_d    = addr_q;
                        fs_inst_d  = NOP;
`ifdef FETCH_ADEL_CHECK_EN
                        adel_d     = 1'b1;
`endif
                    end
                end else if (inst_addr_ok) begin
                    if (redir) begin
                        pend_d  = npc;
                        state_d = S_CANCEL;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (redir) begin
                    addr_d = npc;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    state_d = redir ? S_REQ : S_HOLD;
                    if (redir) begin
                        addr_d = npc;
                    end else begin
                        fs_valid_d = 1'b1;
                        fs_pc_d    = addr_q;
                        fs_inst_d  = inst_rdata;
                    end
                end else if (redir) begin
                    pend_d  = npc;
                    state_d = S_CANCEL;
                end
            end
            S_HOLD: begin
                if (redir || !stall) begin
                    fs_valid_d = 1'b0;
`ifdef FETCH_ADEL_CHECK_EN
                    adel_d     = 1'b0;
`endif
                    addr_d     = npc;
                    state_d    = S_REQ;
                end
            end
            S_CANCEL: begin
                if (inst_data_ok) begin
                    addr_d  = redir ? npc : pend_q;
                    state_d = S_REQ;
                end else if (redir) begin
                    pend_d = npc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            addr_q     <= RESET_PC;
            pend_q     <= RESET_PC;
            fs_valid_q <= 1'b0;
            fs_pc_q    <= RESET_PC;
            fs_inst_q  <= NOP;
`ifdef FETCH_ADEL_CHECK_EN
            adel_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pend_q     <= pend_d;
            fs_valid_q <= fs_valid_d;
            fs_pc_q    <= fs_pc_d;
            fs_inst_q  <= fs_inst_d;
`ifdef FETCH_ADEL_CHECK_EN
            adel_q     <= adel_d;
`endif
        end
    end

    assign inst_req  = (state_q == S_REQ) && !addr_bad;
    assign inst_addr = addr_q;
    assign fs_valid  = fs_valid_q;
    assign fs_pc     = fs_pc_q;
    assign fs_inst   = fs_inst_q;
`ifdef FETCH_ADEL_CHECK_EN
    assign fs_adel   = adel_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a latency-programmable memory model.
// Memory returns ~addr as the instruction word.
module tb_fetch_ctrl;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exception;
    logic        eret;
    logic [31:0] epc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
`ifdef FETCH_ADEL_CHECK_EN
    logic        fs_adel;
`endif

    int checks = 0;
    int errors = 0;
    int lat = 1;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_fs_q[$];

    fetch_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .stall        (stall),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .exception    (exception),
        .eret         (eret),
        .epc          (epc),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .fs_valid     (fs_valid),
        .fs_pc        (fs_pc),
        .fs_inst      (fs_inst)
`ifdef FETCH_ADEL_CHECK_EN
        ,
        .fs_adel      (fs_adel)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory slave: accepts every request, answers after lat cycles.
    initial begin
        logic        s_acc;
        logic [31:0] s_addr;
        logic        busy;
        int          cnt;
        logic [31:0] paddr;
        busy = 1'b0;
        cnt = 0;
        paddr = '0;
        inst_data_ok = 1'b0;
        inst_rdata = '0;
        forever begin
            @(negedge clk);
            s_acc  = inst_req && inst_addr_ok && resetn;
            s_addr = inst_addr;
            @(posedge clk);
            #1;
            inst_data_ok = 1'b0;
            if (!resetn) begin
                busy = 1'b0;
            end else begin
                if (s_acc) begin
                    if (exp_addr_q.size() == 0) begin
                        check("req_unexpected", s_addr, 32'hxxxxxxxx);
                    end else begin
                        check("req_addr", s_addr, exp_addr_q.pop_front());
                    end
                    busy = 1'b1;
                    cnt = lat;
                    paddr = s_addr;
                end
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        inst_data_ok = 1'b1;
                        inst_rdata = ~paddr;
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    // Buffer monitor: each new fs_valid entry is compared to the scoreboard.
    initial begin
        logic        prev;
        logic [63:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (fs_valid && !prev) begin
                if (exp_fs_q.size() == 0) begin
                    check("fs_unexpected", fs_pc, 32'hxxxxxxxx);
                end else begin
                    e = exp_fs_q.pop_front();
                    check("fs_pc", fs_pc, e[63:32]);
                    check("fs_inst", fs_inst, e[31:0]);
                end
            end
            prev = fs_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs_valid && n < 60);
        check(name, {31'd0, fs_valid}, 32'd1);
    endtask

    task automatic expect_fetch(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_fs_q.push_back({a, d});
    endtask

    initial begin
        resetn = 1'b0;
        stall = 1'b0;
        br_valid = 1'b0;
        br_target = '0;
        exception = 1'b0;
        eret = 1'b0;
        epc = '0;
        inst_addr_ok = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, inst_req}, 32'd0);
        check("rst_addr", inst_addr, 32'hbfc00000);
        check("rst_valid", {31'd0, fs_valid}, 32'd0);
        check("rst_pc", fs_pc, 32'hbfc00000);
        check("rst_inst", fs_inst, 32'h0);
`ifdef FETCH_ADEL_CHECK_EN
        check("rst_adel", {31'd0, fs_adel}, 32'd0);
`endif

        // 1: back-to-back sequential fetch, minimum latency
        expect_fetch(32'hbfc00000, 32'h403fffff);
        expect_fetch(32'hbfc00004, 32'h403ffffb);
        expect_fetch(32'hbfc00008, 32'h403ffff7);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_valid("t1_valid");
            if (i == 2) stall = 1'b1;
        end

        // 2: stall holds the buffer, release fetches fs_pc+4
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_valid", {31'd0, fs_valid}, 32'd1);
            check("t2_pc", fs_pc, 32'hbfc00008);
            check("t2_inst", fs_inst, 32'h403ffff7);
            check("t2_req", {31'd0, inst_req}, 32'd0);
        end
        expect_fetch(32'hbfc0000c, 32'h403ffff3);
        stall = 1'b0;
        wait_valid("t2_next");
        stall = 1'b1;

        // 3: branch during WAIT, slow response is discarded
        lat = 3;
        exp_addr_q.push_back(32'hbfc00010);
        expect_fetch(32'hbfc00100, 32'h403ffeff);
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        br_valid = 1'b1;
        br_target = 32'hbfc00100;
        @(negedge clk);
        br_valid = 1'b0;
        lat = 1;
        check("t3_flush", {31'd0, fs_valid}, 32'd0);
        wait_valid("t3_valid");
        stall = 1'b1;

        // 4: all redirects at once in stalled HOLD; exception wins
        exception = 1'b1;
        eret = 1'b1;
        epc = 32'h80000000;
        br_valid = 1'b1;
        br_target = 32'hbfc00200;
        expect_fetch(32'hbfc00380, 32'h403ffc7f);
        @(negedge clk);
        exception = 1'b0;
        eret = 1'b0;
        br_valid = 1'b0;
        check("t4_flush", {31'd0, fs_valid}, 32'd0);
        check("t4_req", {31'd0, inst_req}, 32'd1);
        check("t4_addr", inst_addr, 32'hbfc00380);
        wait_valid("t4_valid");

        // 5: redirect in CANCEL coinciding with data_ok, then wrap
        lat = 3;
        exp_addr_q.push_back(32'hbfc00384);
        expect_fetch(32'hfffffffc, 32'h00000003);
        expect_fetch(32'h00000000, 32'hffffffff);
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        br_valid = 1'b1;
        br_target = 32'hbfc00500;
        @(negedge clk);
        br_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        eret = 1'b1;
        epc = 32'hfffffffc;
        @(negedge clk);
        eret = 1'b0;
        check("t5_addr", inst_addr, 32'hfffffffc);
        wait_valid("t5_valid");
        wait_valid("t5_wrap");
        stall = 1'b1;

`ifdef FETCH_ADEL_CHECK_EN
        // 6: misaligned target produces an address-error entry
        br_valid = 1'b1;
        br_target = 32'hbfc00102;
        exp_fs_q.push_back({32'hbfc00102, 32'h0});
        @(negedge clk);
        br_valid = 1'b0;
        check("t6_noreq", {31'd0, inst_req}, 32'd0);
        @(negedge clk);
        check("t6_valid", {31'd0, fs_valid}, 32'd1);
        check("t6_adel", {31'd0, fs_adel}, 32'd1);
        check("t6_inst", fs_inst, 32'h0);
        check("t6_pc", fs_pc, 32'hbfc00102);
        check("t6_req", {31'd0, inst_req}, 32'd0);
`endif

        repeat (4) @(negedge clk);
        check("addr_q_left", exp_addr_q.size(), 32'd0);
        check("fs_q_left", exp_fs_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
